// File: rtl/sign_mag_add_arbiter.sv
// Round-robin arbiter that time-shares one synchronous sign-magnitude adder ROM
// among NUM_REQ requesters, one transaction in flight at a time.
module sign_mag_add_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int ROM_LAT = 1,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [4*NUM_REQ-1:0]   req_a,
   input  logic [4*NUM_REQ-1:0]   req_b,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   rom_en,
   output logic [7:0]             rom_addr,
   input  logic [4:0]             rom_data,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [4:0]             rsp_sum,
   output logic                   busy,
   output logic [1:0]             dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready, and payload is held until transfer.

   localparam int CW = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [7:0]       addr_q, addr_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [4:0]       rsp_sum_q, rsp_sum_d;

   logic             grant_found;
   logic [IDW-1:0]   grant_idx;
   logic [IDW-1:0]   next_ptr;

   // Rotating priority search starting at rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(idx);
         end
      end
      next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= '0;
         cnt_q     <= '0;
         addr_q    <= '0;
         id_q      <= '0;
         rsp_id_q  <= '0;
         rsp_sum_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         id_q      <= id_d;
         rsp_id_q  <= rsp_id_d;
         rsp_sum_q <= rsp_sum_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      id_d      = id_q;
      rsp_id_d  = rsp_id_q;
      rsp_sum_d = rsp_sum_q;
      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               addr_d   = {req_a[4*int'(grant_idx) +: 4], req_b[4*int'(grant_idx) +: 4]};
               id_d     = grant_idx;
               rr_ptr_d = next_ptr;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = CW'(ROM_LAT - 1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Counter reaching zero marks the cycle rom_data is valid.
            if (cnt_q == '0) begin
               rsp_sum_d = rom_data;
               rsp_id_d  = id_q;
               state_d   = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      // Gated by rst_n so the grant is quiet while reset is held.
      if (rst_n && state_q == S_IDLE && grant_found)
         req_ready = NUM_REQ'(1) << grant_idx;
      rom_en    = (state_q == S_ISSUE);
      rsp_valid = (state_q == S_RESP);
      busy      = (state_q != S_IDLE);
      rom_addr  = addr_q;
      rsp_id    = rsp_id_q;
      rsp_sum   = rsp_sum_q;
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_sign_mag_add_arbiter.sv
// Directed scoreboard bench for sign_mag_add_arbiter: stimulus pushes expected
// grants, ROM addresses and responses; a negedge monitor pops and compares.
module tb_sign_mag_add_arbiter;

   localparam int NUM_REQ = 4;
   localparam int IDW     = 2;
   localparam int LAT     = 1;
   localparam int LAT3    = 3;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic [NUM_REQ-1:0]   req_valid, req_ready;
   logic [4*NUM_REQ-1:0] req_a, req_b;
   logic                 rom_en, rsp_valid, rsp_ready, busy;
   logic [7:0]           rom_addr;
   logic [4:0]           rom_data, rsp_sum;
   logic [IDW-1:0]       rsp_id;
   logic [1:0]           dbg_state;

   logic [NUM_REQ-1:0]   req_valid3, req_ready3;
   logic                 rom_en3, rsp_valid3, busy3;
   logic [7:0]           rom_addr3;
   logic [4:0]           rom_data3, rsp_sum3;
   logic [IDW-1:0]       rsp_id3;
   logic [1:0]           dbg_state3;

   logic [3:0] lane_a   [NUM_REQ];
   logic [3:0] lane_b   [NUM_REQ];
   logic [4:0] lane_sum [NUM_REQ];

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_a[4*i +: 4] = lane_a[i];
         req_b[4*i +: 4] = lane_b[i];
      end
   end

   sign_mag_add_arbiter #(.NUM_REQ(NUM_REQ), .ROM_LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .busy(busy), .dbg_state(dbg_state)
   );

   sign_mag_add_arbiter #(.NUM_REQ(NUM_REQ), .ROM_LAT(LAT3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready3), .rom_en(rom_en3), .rom_addr(rom_addr3), .rom_data(rom_data3),
      .rsp_valid(rsp_valid3), .rsp_ready(1'b1), .rsp_id(rsp_id3), .rsp_sum(rsp_sum3),
      .busy(busy3), .dbg_state(dbg_state3)
   );

   // ---------------- ROM models ----------------
   function automatic logic [4:0] sm_add(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] ma, mb;
      ma = {1'b0, a[2:0]};
      mb = {1'b0, b[2:0]};
      if (a[3] == b[3])  return {a[3], ma + mb};
      else if (ma >= mb) return {a[3], ma - mb};
      else               return {b[3], mb - ma};
   endfunction

   logic [4:0] rom_pipe  [LAT];
   logic [4:0] rom_pipe3 [LAT3];
   always @(posedge clk) begin
      if (rom_en) rom_pipe[0] <= sm_add(rom_addr[7:4], rom_addr[3:0]);
      for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
      if (rom_en3) rom_pipe3[0] <= sm_add(rom_addr3[7:4], rom_addr3[3:0]);
      for (int i = 1; i < LAT3; i++) rom_pipe3[i] <= rom_pipe3[i-1];
   end
   assign rom_data  = rom_pipe[LAT-1];
   assign rom_data3 = rom_pipe3[LAT3-1];

   // ---------------- scoreboard ----------------
   logic [IDW+4:0] exp_q  [$];
   logic [IDW-1:0] gnt_q  [$];
   logic [7:0]     addr_q [$];
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- driver tasks ----------------
   logic sp_chk  = 1'b0;
   logic acc_chk = 1'b0;

   task automatic expect_grant(input int idx, input bit with_rsp);
      gnt_q.push_back(IDW'(idx));
      addr_q.push_back({lane_a[idx], lane_b[idx]});
      if (with_rsp) exp_q.push_back({IDW'(idx), lane_sum[idx]});
   endtask

   task automatic wait_grants();
      int n = 0;
      while (gnt_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("grant_wait_bound", gnt_q.size(), 0);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_wait_bound", exp_q.size(), 0);
   endtask

   task automatic run_phase(input logic [NUM_REQ-1:0] vld);
      req_valid = vld;
      wait_grants();
      req_valid = '0;
      wait_drain();
   endtask

   // ---------------- monitor ----------------
   int   t_hs = 0, prev_hs = 0, acc_cyc = 0;
   bit   have_prev = 0, have_acc = 0, rv_prev = 0, en_prev = 0, hold_pend = 0;
   logic [IDW+4:0] hold_val;

   always @(negedge clk) begin
      logic [IDW-1:0] g;
      if (!rst_n) begin
         have_prev = 0; have_acc = 0; rv_prev = 0; en_prev = 0; hold_pend = 0;
      end else begin
         if (!sp_chk)  have_prev = 0;
         if (!acc_chk) have_acc  = 0;
         if (|(req_valid & req_ready)) begin
            if (gnt_q.size() == 0) check("unexpected_grant", req_ready, 0);
            else begin
               g = gnt_q.pop_front();
               check("grant_onehot", req_ready, 32'(1) << g);
               if (have_prev) check("grant_spacing", cyc - prev_hs, LAT + 3);
               if (have_acc)  check("grant_after_accept", cyc, acc_cyc + 1);
            end
            t_hs = cyc;
            if (sp_chk) begin prev_hs = cyc; have_prev = 1; end
         end
         if (en_prev) check("rom_en_one_cycle", rom_en, 0);
         if (rom_en) begin
            if (addr_q.size() == 0) check("unexpected_rom_en", rom_en, 0);
            else begin
               check("rom_addr", rom_addr, addr_q.pop_front());
               check("rom_en_latency", cyc, t_hs + 1);
               check("busy_in_issue", busy, 1);
            end
         end
         if (hold_pend) check("rsp_hold", {rsp_valid, rsp_id, rsp_sum}, {1'b1, hold_val});
         if (rsp_valid) begin
            check("req_ready_in_resp", req_ready, 0);
            if (!rv_prev) check("rsp_latency", cyc, t_hs + LAT + 2);
            if (rsp_ready) begin
               if (exp_q.size() == 0) check("unexpected_rsp", rsp_valid, 0);
               else check("rsp_id_sum", {rsp_id, rsp_sum}, exp_q.pop_front());
               if (acc_chk) begin acc_cyc = cyc; have_acc = 1; end
            end
         end
         hold_pend = rsp_valid && !rsp_ready;
         hold_val  = {rsp_id, rsp_sum};
         rv_prev   = rsp_valid;
         en_prev   = rom_en;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      req_valid  = '0;
      req_valid3 = '0;
      rsp_ready  = 1'b1;
      // hand-computed sign-magnitude sums
      lane_a[0] = 4'b0001; lane_b[0] = 4'b1010; lane_sum[0] = 5'b10001; // +1 + -2 = -1
      lane_a[1] = 4'b0011; lane_b[1] = 4'b0100; lane_sum[1] = 5'b00111; // +3 + +4 = +7
      lane_a[2] = 4'b1101; lane_b[2] = 4'b0010; lane_sum[2] = 5'b10011; // -5 + +2 = -3
      lane_a[3] = 4'b1000; lane_b[3] = 4'b1000; lane_sum[3] = 5'b10000; // -0 + -0 = -0

      // reset state, with requests pending
      repeat (2) @(posedge clk);
      #1 req_valid = 4'b1111;
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_rom_en", rom_en, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_rsp_valid", {rsp_valid, rsp_id, rsp_sum}, 0);
      check("rst_busy", busy, 0);
      check("rst_state", dbg_state, 0);
      req_valid = '0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // single request, then negative zero on lane 3 (rr_ptr returns to 0)
      expect_grant(0, 1);
      run_phase(4'b0001);
      expect_grant(3, 1);
      run_phase(4'b1000);

      // full contention
      sp_chk = 1'b1; acc_chk = 1'b1;
      expect_grant(0, 1); expect_grant(1, 1); expect_grant(2, 1);
      expect_grant(3, 1); expect_grant(0, 1);
      run_phase(4'b1111);
      sp_chk = 1'b0; acc_chk = 1'b0;

      // pointer wrap: grant 2 leaves rr_ptr=3, then 0 wins over 2
      expect_grant(2, 1);
      run_phase(4'b0100);
      sp_chk = 1'b1; acc_chk = 1'b1;
      expect_grant(0, 1); expect_grant(2, 1);
      run_phase(4'b0101);
      sp_chk = 1'b0; acc_chk = 1'b0;

      // backpressure, with max-magnitude operands on lane 1
      lane_a[1] = 4'b0111; lane_b[1] = 4'b0111; lane_sum[1] = 5'b01110; // +7 + +7 = +14
      rsp_ready = 1'b0; acc_chk = 1'b1;
      expect_grant(0, 1); expect_grant(1, 1);
      req_valid = 4'b0011;
      n = 0;
      while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("bp_rsp_seen", rsp_valid, 1);
      repeat (5) @(posedge clk);
      #1 rsp_ready = 1'b1;
      wait_grants();
      req_valid = '0;
      wait_drain();
      acc_chk = 1'b0;

      // reset during WAIT; rr_ptr would be 3 without the reset
      expect_grant(2, 0);
      req_valid = 4'b0100;
      wait_grants();
      req_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rom_addr", rom_addr, 0);
      check("mid_rst_rsp", {rsp_id, rsp_sum}, 0);
      req_valid = 4'b1010;
      #1;
      check("mid_rst_req_ready", req_ready, 0);
      sp_chk = 1'b1; acc_chk = 1'b1;
      expect_grant(1, 1); expect_grant(3, 1);
      @(negedge clk) rst_n = 1'b1;
      wait_grants();
      req_valid = '0;
      wait_drain();
      sp_chk = 1'b0; acc_chk = 1'b0;
      check("end_busy", busy, 0);

      // ROM_LAT=3 build, single-request stimulus
      @(posedge clk); #1 req_valid3 = 4'b0001;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready3[0] && n < 20);
      check("l3_grant", req_ready3, 4'b0001);
      @(negedge clk);
      req_valid3 = '0;
      check("l3_rom_en", rom_en3, 1);
      check("l3_rom_addr", rom_addr3, 8'h1A);
      @(negedge clk);
      check("l3_rom_en_once", rom_en3, 0);
      repeat (2) @(negedge clk);
      check("l3_rsp_early", rsp_valid3, 0);
      @(negedge clk);
      check("l3_rsp", {rsp_valid3, rsp_id3, rsp_sum3}, {1'b1, 2'd0, 5'b10001});
      @(negedge clk);
      check("l3_rsp_done", rsp_valid3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sign_mag_add_arbiter.md
Name: sign_mag_add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one synchronous-ROM sign-magnitude adder among NUM_REQ requesters.
- Each requester presents a 4-bit sign-magnitude operand pair with a valid/ready handshake. The block drives the ROM address, waits out the ROM latency, and returns the 5-bit sum tagged with the requester index.
- Only one transaction is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ROM_LAT, 1, ROM read latency in cycles from rom_en high to rom_data valid; legal range 1..4.
- IDW, $clog2(NUM_REQ), localparam, width of the requester id.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  4*NUM_REQ  operand a; requester i uses bits [4i+3:4i]; bit 3 is sign, bits [2:0] are magnitude.
- req_b  in  4*NUM_REQ  operand b; same packing as req_a.
- req_ready  out  NUM_REQ  one-hot grant; a handshake occurs when req_valid[i] and req_ready[i] are both high.
- rom_en  out  1  ROM read strobe, high for one cycle per transaction.
- rom_addr  out  8  ROM address, {a,b}.
- rom_data  in  5  ROM sum; bit 4 is sign, bits [3:0] are magnitude.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_sum  out  5  captured sum.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous): state=IDLE, rr_ptr=0, wait counter=0. Outputs: req_ready=0, rom_en=0, rom_addr=0, rsp_valid=0, rsp_id=0, rsp_sum=0, busy=0. Any in-flight transaction is dropped and not replayed.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbitration is combinational. Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ; the first set bit is the winner g.
  - req_ready[g]=1 in this same cycle and all other bits are 0. No valid requests gives req_ready=0.
  - On the handshake edge: latch {req_a[g],req_b[g]} into rom_addr, latch g into the id register, set rr_ptr=(g+1) mod NUM_REQ, go to ISSUE.
- ISSUE: rom_en=1 for exactly this cycle; rom_addr is stable. Load the wait counter with ROM_LAT-1 and go to WAIT.
- WAIT:
  - Lasts ROM_LAT cycles.
  - In the final WAIT cycle, rom_data is valid. Register it into rsp_sum and the id into rsp_id, then go to RESP.
- RESP:
  - rsp_valid=1. rsp_sum and rsp_id are held stable until the cycle where rsp_valid and rsp_ready are both high.
  - On that edge: rsp_valid=0, go to IDLE.
  - No arbitration happens in RESP.
- Latency with handshake in cycle T: rom_en high in T+1; rom_data sampled at the end of T+ROM_LAT+1; rsp_valid first high in T+ROM_LAT+2.
- Throughput with rsp_ready tied high: one transaction per ROM_LAT+3 cycles (4 cycles at the default).
- rom_addr holds its last value between transactions. rom_en is 0 outside ISSUE.
- A requester may drop req_valid before being granted; no transaction results. req_a/req_b are sampled only on the handshake edge.
- rr_ptr advances only on a grant. Any continuously-valid requester is granted within NUM_REQ transactions.
- Operands pass through unmodified, including negative zero (4'b1000). The block does no arithmetic; the sum encoding is defined by the ROM contents.
- Reset asserted in any state returns all outputs to their reset values immediately, without waiting for a clock edge.

Test Plan:
- Single request: req_valid=4'b0001, a=4'b0001 (+1), b=4'b1010 (-2), ROM model returns 5'b10001 (-1). Required: req_ready[0] in the handshake cycle T, rom_addr=8'h1A with rom_en=1 in T+1, rsp_valid in T+3 with rsp_sum=5'b10001 and rsp_id=0.
- Full contention: req_valid=4'b1111 held, rsp_ready=1. Required grant order 0,1,2,3,0, one grant every 4 cycles, and rsp_id matches each grant.
- Pointer wrap: rr_ptr=3 after granting requester 2, then req_valid=4'b0101. Required: requester 0 granted next, then requester 2.
- Backpressure: rsp_ready=0 for 5 cycles during RESP. Required: rsp_valid, rsp_sum and rsp_id stable; req_ready=0 throughout; next grant in the cycle after the accept edge.
- Reset mid-operation: rst_n=0 during WAIT. Required: rsp_valid=0, busy=0, rr_ptr=0 immediately; after release with req_valid=4'b1010, requester 1 is granted first.
- ROM_LAT=3 build: same stimulus as the single-request scenario. Required: rsp_valid in T+5 with the same sum; rom_en high for exactly one cycle.
